// File: rtl/mips_cpu_instr_memory.sv
// Instruction memory for the MIPS CPU: filled by a streaming loader, then serves fetches until address 0 halts it.
// Optional macro IMEM_FETCH_COUNT_EN adds a free-running count of RUN cycles on fetch_count.
module mips_cpu_instr_memory #(
    parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
    parameter int          DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        run,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            fault_q, fault_d;
    logic [31:0]     mem_q [DEPTH];

    logic [31:0]     offset;
    logic            addr_legal;
    logic            addr_zero;
    logic [AW-1:0]   rd_idx;
    logic            transfer;

    // Subtracting the base first makes the range check immune to BASE_ADDR+size wrapping.
    assign offset     = instr_address - BASE_ADDR;
    assign addr_legal = (offset[1:0] == 2'b00) && (offset < MEM_BYTES);
    assign addr_zero  = (instr_address == 32'd0);
    assign rd_idx     = offset[AW+1:2];

    assign load_ready = (state_q == S_LOAD) && clk_enable;
    assign transfer   = load_valid && load_ready;

    assign run    = (state_q != S_LOAD);
    assign halted = (state_q == S_HALT);
    assign fault  = fault_q;

    assign instr_readdata = (state_q == S_RUN && addr_legal && !addr_zero) ? mem_q[rd_idx] : 32'd0;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        fault_d  = fault_q;
        if (clk_enable) begin
            case (state_q)
                S_LOAD: begin
                    if (transfer) begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (load_last || wr_ptr_q == AW'(DEPTH - 1)) begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Address 0 is the program-end marker, never a fault.
                    if (addr_zero) begin
                        state_d = S_HALT;
                    end else if (!addr_legal) begin
                        fault_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_LOAD;
            wr_ptr_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            fault_q  <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (transfer) begin
            mem_q[wr_ptr_q] <= load_data;
        end
    end

`ifdef IMEM_FETCH_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (clk_enable && state_q == S_RUN) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// Directed bench for mips_cpu_instr_memory; expected outputs go through a scoreboard queue.
module tb_mips_cpu_instr_memory;

`ifdef IMEM_FETCH_COUNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        run;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sbItem_t;

    sbItem_t     sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] fcExp  = 32'd0;

    mips_cpu_instr_memory dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .instr_address (instr_address),
        .instr_readdata(instr_readdata),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .run           (run),
        .halted        (halted),
        .fault         (fault),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input bit countsRun);
        @(posedge clk);
        if (countsRun && FC_EN) fcExp = fcExp + 32'd1;
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic lv,
                                 input logic [31:0] ld, input logic ll, input logic [31:0] addr);
        reset         = rst;
        clk_enable    = en;
        load_valid    = lv;
        load_data     = ld;
        load_last     = ll;
        instr_address = addr;
    endtask

    task automatic expectOut(input string tag, input logic [31:0] val);
        sbItem_t it;
        it.tag = tag;
        it.val = val;
        sb.push_back(it);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        sbItem_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard: observed %h expected queued entry", observed);
        end else begin
            it = sb.pop_front();
            assert (observed === it.val) else begin
                errors++;
                $error("[TB] FAIL %s: observed %h expected %h", it.tag, observed, it.val);
            end
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] rd, input logic r,
                            input logic h, input logic f, input logic rdy);
        expectOut({tag, ".rd"}, rd);
        expectOut({tag, ".run"}, {31'd0, r});
        expectOut({tag, ".halted"}, {31'd0, h});
        expectOut({tag, ".fault"}, {31'd0, f});
        expectOut({tag, ".ready"}, {31'd0, rdy});
        expectOut({tag, ".fc"}, fcExp);
        #1;
        checkOutput(instr_readdata);
        checkOutput({31'd0, run});
        checkOutput({31'd0, halted});
        checkOutput({31'd0, fault});
        checkOutput({31'd0, load_ready});
        checkOutput(fetch_count);
    endtask

    task automatic checkRead(input string tag, input logic [31:0] addr, input logic [31:0] rd);
        instr_address = addr;
        expectOut(tag, rd);
        #1;
        checkOutput(instr_readdata);
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'hBFC00000);
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
        fcExp = 32'd0;
        checkAll("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Three-word load ending on load_last
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h24420001, 1'b0, 32'hBFC00000);
        tick(1'b0);
        tick(1'b0);
        checkAll("load2", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        load_last = 1'b1;
        tick(1'b0);
        load_valid = 1'b0;
        load_last  = 1'b0;
        instr_address = 32'hBFC00008;
        checkAll("run_entry", 32'h24420001, 1'b1, 1'b0, 1'b0, 1'b0);
        checkRead("word3_nop", 32'hBFC0000C, 32'd0);
        checkRead("word0", 32'hBFC00000, 32'h24420001);

        // Loader ignored in RUN
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'hBFC0000C);
        tick(1'b1);
        checkAll("run_ignore_load", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        load_valid = 1'b0;
        load_last  = 1'b0;

        // Illegal fetches
        instr_address = 32'hBFC00002;
        checkAll("misaligned_pre", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1);
        checkAll("misaligned_post", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        instr_address = 32'h00001000;
        tick(1'b1);
        checkAll("outside_post", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkRead("past_end", 32'hBFC00100, 32'd0);
        checkRead("last_word_nop", 32'hBFC000FC, 32'd0);

        // Halt on address 0
        instr_address = 32'h00000000;
        checkAll("halt_pre", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b1);
        instr_address = 32'hBFC00000;
        checkAll("halt_post", 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b0);
        checkAll("halt_hold", 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset beats a concurrent last transfer
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h55555555, 1'b1, 32'hBFC00000);
        tick(1'b0);
        fcExp = 32'd0;
        reset = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        checkAll("reset_vs_transfer", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // clk_enable low during LOAD blocks transfers
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1, 32'hBFC00000);
        checkAll("en_low_ready", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0);
        checkAll("en_low_hold", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hA0A0A0A0, 1'b0, 32'hBFC00000);
        tick(1'b0);
        load_data = 32'hA1A1A1A1;
        load_last = 1'b1;
        tick(1'b0);
        load_valid = 1'b0;
        load_last  = 1'b0;
        checkAll("en_resume_w0", 32'hA0A0A0A0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkRead("en_resume_w1", 32'hBFC00004, 32'hA1A1A1A1);
        checkRead("en_resume_w2", 32'hBFC00008, 32'd0);

        // clk_enable low in RUN: no halt, no fault, reads stay live
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h00000000);
        tick(1'b0);
        instr_address = 32'hBFC00001;
        tick(1'b0);
        instr_address = 32'hBFC00004;
        checkAll("run_en_low", 32'hA1A1A1A1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in mid-run after a fault
        clk_enable    = 1'b1;
        instr_address = 32'hBFC00003;
        tick(1'b1);
        instr_address = 32'hBFC00004;
        checkAll("fault_before_reset", 32'hA1A1A1A1, 1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        fcExp = 32'd0;
        checkAll("reset_mid_run", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Full-depth load without load_last
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'hBFC00000);
        for (int i = 0; i < 64; i++) begin
            load_data = 32'h10000000 + 32'(i);
            if (i == 63) checkAll("fill_before_last", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick(1'b0);
        end
        load_data = 32'hEEEEEEEE;
        checkAll("fill_run", 32'h10000000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1);
        checkAll("fill_no_wrap", 32'h10000000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkRead("fill_w63", 32'hBFC000FC, 32'h1000003F);
        checkRead("fill_w32", 32'hBFC00080, 32'h10000020);
        load_valid = 1'b0;

        // Fetch count across ten RUN cycles ending in halt
        instr_address = 32'hBFC00010;
        for (int i = 0; i < 8; i++) tick(1'b1);
        instr_address = 32'h00000000;
        tick(1'b1);
        expectOut("fc_ten", FC_EN ? 32'd10 : 32'd0);
        checkOutput(fetch_count);
        instr_address = 32'hBFC00010;
        checkAll("fc_halted", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0);
        checkAll("fc_hold", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_instr_memory.md
MIPS_CPU_INSTR_MEMORY -- requirements
Module: mips_cpu_instr_memory

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hBFC00000: byte address of word 0, the reset vector.
REQ-002 SHALL have parameter DEPTH, default 64: number of 32-bit words; legal range 2..1024, power of two.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port clk_enable  input  1  when low, all state holds; combinational outputs stay valid.
REQ-006 SHALL have port instr_address  input  32  CPU fetch byte address.
REQ-007 SHALL have port instr_readdata  output  32  fetched instruction word, combinational from instr_address.
REQ-008 SHALL have port load_valid  input  1  loader word present.
REQ-009 SHALL have port load_data  input  32  loader instruction word.
REQ-010 SHALL have port load_last  input  1  qualifies the final loader word.
REQ-011 SHALL have port load_ready  output  1  memory accepts a loader word this cycle.
REQ-012 SHALL have port run  output  1  program loaded; the CPU's reset is driven from !run.
REQ-013 SHALL have port halted  output  1  the CPU fetched address 0 (program end).
REQ-014 SHALL have port fault  output  1  sticky flag: illegal fetch seen.
REQ-015 SHALL have port fetch_count  output  32  number of RUN cycles (see Configuration).

Function
REQ-016 SHALL implement FSM LOAD -> RUN -> HALT; HALT is left only by reset.
REQ-017 In LOAD: load_ready = clk_enable; instr_readdata = 0; run = 0.
REQ-018 A transfer SHALL occur on a rising edge with load_valid && load_ready: mem[wr_ptr] <= load_data, wr_ptr <= wr_ptr+1.
REQ-019 LOAD -> RUN SHALL occur on the edge of a transfer with load_last=1, or of the transfer into word DEPTH-1, whichever comes first.
REQ-020 load_valid with load_ready low (clk_enable=0) SHALL neither write nor advance wr_ptr.
REQ-021 In RUN: run = 1; load_ready = 0; loader inputs are ignored.
REQ-022 In RUN, for a legal address SHALL drive instr_readdata = mem[(instr_address-BASE_ADDR)>>2] with zero latency. A legal address is word-aligned and inside BASE_ADDR..BASE_ADDR+4*DEPTH-1.
REQ-023 Words never written since reset SHALL read 0 (NOP).
REQ-024 In RUN, instr_address==0 sampled on an enabled edge SHALL move the FSM to HALT; halted = 1 from the next cycle.
REQ-025 In RUN, a fetch of an illegal address other than 0 SHALL return 0, and SHALL set fault on the next enabled edge; fault is sticky until reset.
REQ-026 In HALT: instr_readdata = 0; run stays 1; halted = 1; fault holds.
REQ-027 Address 0 and an illegal address never coincide: address 0 takes the HALT path only.

Reset
REQ-028 On reset SHALL set: FSM=LOAD, wr_ptr=0, every mem word=0, run=0, halted=0, fault=0, fetch_count=0.
REQ-029 Reset SHALL have priority over clk_enable and over any transfer in the same cycle; this includes reset in mid-load or mid-run.

Configuration
REQ-030 Macro IMEM_FETCH_COUNT_EN defined: fetch_count SHALL increment by 1 on every enabled edge while in RUN, wrapping 32'hFFFFFFFF -> 0, and hold in LOAD/HALT.
REQ-031 Macro IMEM_FETCH_COUNT_EN undefined: fetch_count SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-032 Reset, then load 3 words 0x24420001 (last on 3rd) -> run=1 one cycle after the 3rd transfer; fetch 0xBFC00008 returns 0x24420001, fetch 0xBFC0000C returns 0.
REQ-033 Load DEPTH words with load_last never asserted -> RUN entered after word DEPTH-1; a further load_valid sees load_ready=0 and no write.
REQ-034 In RUN, fetch 0xBFC00002 and 0x00001000 -> instr_readdata=0, fault=1 next cycle; halted stays 0.
REQ-035 In RUN, fetch 0x00000000 -> halted=1 next cycle; fetch 0xBFC00000 afterwards returns 0.
REQ-036 Hold clk_enable=0 for 5 cycles during LOAD with load_valid=1 -> wr_ptr and fetch_count unchanged; assert reset mid-RUN -> all outputs return to reset values.
REQ-037 With IMEM_FETCH_COUNT_EN: 10 enabled RUN cycles, then halt -> fetch_count=10 and holds thereafter.
